rect_fill_arbiter: RTL



---
 rtl/rect_fill_arbiter_if.sv | 43 ++++
 rtl/rect_fill_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_arbiter_if.sv
// Requester and framebuffer-write bundle for rect_fill_arbiter.
// RECT_OUTLINE_EN adds the per-requester req_outline input.
interface rect_fill_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int COLOR_W = 16,
  parameter int GW      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*7-1:0]       req_x0;
  logic [NUM_REQ*6-1:0]       req_y0;
  logic [NUM_REQ*7-1:0]       req_x1;
  logic [NUM_REQ*6-1:0]       req_y1;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
`ifdef RECT_OUTLINE_EN
  logic [NUM_REQ-1:0]         req_outline;
`endif
  logic [NUM_REQ-1:0]         ack;
  logic                       busy;
  logic [GW-1:0]              grant_id;
  logic                       wr_en;
  logic [12:0]                wr_addr;
  logic [COLOR_W-1:0]         wr_data;

  modport master (
`ifdef RECT_OUTLINE_EN
    output req_outline,
`endif
    output req, req_x0, req_y0,
    output req_x1, req_y1, req_color,
    input  ack, busy, grant_id,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
`ifdef RECT_OUTLINE_EN
    input  req_outline,
`endif
    input  req, req_x0, req_y0,
    input  req_x1, req_y1, req_color,
    output ack, busy, grant_id,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rect_fill_arbiter.sv
// Round-robin rectangle fill engine for the 96x64 OLED framebuffer.
// Define RECT_OUTLINE_EN to enable outline-only (perimeter) fills.
module rect_fill_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int COLOR_W = 16,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  rect_fill_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  localparam logic [6:0] XMAX = 7'(WIDTH - 1);
  localparam logic [5:0] YMAX = 6'(HEIGHT - 1);

  state_e               state_q, state_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [6:0]           x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
  logic [5:0]           y1_q, y1_d, cy_q, cy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 wr_en_q, wr_en_d;
  logic [12:0]          wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]   wr_data_q, wr_data_d;

  logic                 gnt_vld;
  logic [GW-1:0]        gnt_idx;
  logic [6:0]           sx0, sx1, sx1c, nx;
  logic [5:0]           sy0, sy1, sy1c, ny;
  logic [COLOR_W-1:0]   scol;
  logic                 empty, last_col, last_pix, jump;

  function automatic logic [12:0] pix_addr(
    input logic [5:0] y,
    input logic [6:0] x
  );
    return 13'(y) * 13'(WIDTH) + 13'(x);
  endfunction

  // Lowest k wins: iterate downward so it is assigned last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(last_q) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign sx0  = bus.req_x0[gnt_idx*7 +: 7];
  assign sy0  = bus.req_y0[gnt_idx*6 +: 6];
  assign sx1  = bus.req_x1[gnt_idx*7 +: 7];
  assign sy1  = bus.req_y1[gnt_idx*6 +: 6];
  assign scol = bus.req_color[gnt_idx*COLOR_W +: COLOR_W];
  assign sx1c = (sx1 > XMAX) ? XMAX : sx1;
  assign sy1c = (sy1 > YMAX) ? YMAX : sy1;
  // x1/y1 are already clamped, so an off-screen origin is caught here too.
  assign empty = (sx0 > sx1c) || (sy0 > sy1c);

  assign last_col = (cx_q == x1_q);
  assign last_pix = last_col && (cy_q == y1_q);

`ifdef RECT_OUTLINE_EN
  logic       outline_q, outline_d;
  logic [5:0] y0_q, y0_d;
  assign jump = outline_q && (cx_q == x0_q) &&
                (cy_q != y0_q) && (cy_q != y1_q);
`else
  assign jump = 1'b0;
`endif

  always_comb begin
    nx = cx_q + 7'd1;
    ny = cy_q;
    if (last_col) begin
      nx = x0_q;
      ny = cy_q + 6'd1;
    end else if (jump) begin
      nx = x1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    ack_d     = '0;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef RECT_OUTLINE_EN
    outline_d = outline_q;
    y0_d      = y0_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant_d   = gnt_idx;
          x0_d      = sx0;
          x1_d      = sx1c;
          y1_d      = sy1c;
          cx_d      = sx0;
          cy_d      = sy0;
          busy_d    = 1'b1;
          wr_data_d = scol;
`ifdef RECT_OUTLINE_EN
          outline_d = bus.req_outline[gnt_idx];
          y0_d      = sy0;
`endif
          if (empty) begin
            state_d = DONE;
            ack_d   = NUM_REQ'(1) << gnt_idx;
          end else begin
            state_d   = FILL;
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr(sy0, sx0);
          end
        end
      end
      FILL: begin
        if (last_pix) begin
          state_d = DONE;
          ack_d   = NUM_REQ'(1) << grant_q;
        end else begin
          cx_d      = nx;
          cy_d      = ny;
          wr_en_d   = 1'b1;
          wr_addr_d = pix_addr(ny, nx);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef RECT_OUTLINE_EN
      outline_q <= 1'b0;
      y0_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef RECT_OUTLINE_EN
      outline_q <= outline_d;
      y0_q      <= y0_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule
